// File: rtl/sw_job_ctrl.sv
// rtl/sw_job_ctrl.sv - job sequencer, watchdog and result FIFO for the SmithWaterman core
module sw_job_ctrl #(
    parameter int CALC_W     = 16,
    parameter int TIDX_W     = 10,
    parameter int MATCH_W    = 8,
    parameter int QIDX_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 50000,
    parameter int START_WIN  = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid_i,
    output logic               cmd_ready_o,
    input  logic [QIDX_W-1:0]  cmd_nq_i,
    input  logic [MATCH_W-1:0] cmd_match_i,
    input  logic [MATCH_W-1:0] cmd_mismatch_i,
    input  logic [MATCH_W-1:0] cmd_alpha_i,
    input  logic [MATCH_W-1:0] cmd_beta_i,
    output logic [MATCH_W-1:0] sw_match_o,
    output logic [MATCH_W-1:0] sw_mismatch_o,
    output logic [MATCH_W-1:0] sw_alpha_o,
    output logic [MATCH_W-1:0] sw_beta_o,
    output logic               sw_start_o,
    input  logic               sw_busy_i,
    input  logic               sw_valid_i,
    input  logic               sw_change_q_i,
    input  logic [TIDX_W-1:0]  sw_match_idx_i,
    input  logic [CALC_W-1:0]  sw_max_result_i,
    output logic               res_valid_o,
    input  logic               res_ready_i,
    output logic [QIDX_W-1:0]  res_q_idx_o,
    output logic [TIDX_W-1:0]  res_t_idx_o,
    output logic [CALC_W-1:0]  res_score_o,
    output logic               done_o,
    output logic [QIDX_W-1:0]  q_cnt_o,
    output logic               err_timeout_o,
    output logic               err_ovf_o,
    output logic               err_short_o
);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int EW   = QIDX_W + TIDX_W + CALC_W;
    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam int SW_W = $clog2(START_WIN + 1);

    typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_WAIT_BUSY, S_RUN, S_DONE} state_t;
    state_t state, state_nx;

    logic [WD_W-1:0]   wd_cnt;
    logic [SW_W-1:0]   win_cnt;
    logic [QIDX_W-1:0] nq;
    logic [QIDX_W-1:0] q_nx;
    logic [EW-1:0]     mem [FIFO_DEPTH];
    logic [AW:0]       wr_ptr, rd_ptr;
    logic [EW-1:0]     head;
    logic accept, run, push_req, pop, full, empty, drop, to_hit, win_hit;

    assign cmd_ready_o = rst_n & ((state == S_IDLE) | (state == S_DONE));
    assign accept      = cmd_valid_i & cmd_ready_o;
    assign run         = (state == S_RUN);
    assign done_o      = (state == S_DONE);
    assign push_req    = run & sw_valid_i & sw_change_q_i;
    assign empty       = (wr_ptr == rd_ptr);
    assign full        = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop         = ~empty & res_ready_i;
    // The core cannot be stalled, so a push into a full FIFO is lost unless a pop frees a slot.
    assign drop        = push_req & full & ~pop;
    assign q_nx        = push_req ? q_cnt_o + 1'b1 : q_cnt_o;
    assign win_hit     = ~sw_busy_i && (win_cnt == SW_W'(START_WIN - 1));
    assign to_hit      = ~sw_valid_i && (wd_cnt == WD_W'(TIMEOUT - 1));

    assign head        = mem[rd_ptr[AW-1:0]];
    assign res_valid_o = ~empty;
    assign res_q_idx_o = empty ? '0 : head[EW-1 -: QIDX_W];
    assign res_t_idx_o = empty ? '0 : head[CALC_W +: TIDX_W];
    assign res_score_o = empty ? '0 : head[CALC_W-1:0];

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE, S_DONE: if (accept) state_nx = S_LAUNCH;
            S_LAUNCH:       state_nx = S_WAIT_BUSY;
            S_WAIT_BUSY:    if (sw_busy_i) state_nx = S_RUN;
                            else if (win_hit) state_nx = S_DONE;
            S_RUN:          if (~sw_busy_i || to_hit) state_nx = S_DONE;
            default:        state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            sw_start_o    <= 1'b0;
            sw_match_o    <= '0;
            sw_mismatch_o <= '0;
            sw_alpha_o    <= '0;
            sw_beta_o     <= '0;
            nq            <= '0;
            q_cnt_o       <= '0;
            err_timeout_o <= 1'b0;
            err_ovf_o     <= 1'b0;
            err_short_o   <= 1'b0;
            wd_cnt        <= '0;
            win_cnt       <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
        end else begin
            state      <= state_nx;
            sw_start_o <= (state_nx == S_LAUNCH);
            if (accept) begin
                sw_match_o    <= cmd_match_i;
                sw_mismatch_o <= cmd_mismatch_i;
                sw_alpha_o    <= cmd_alpha_i;
                sw_beta_o     <= cmd_beta_i;
                nq            <= cmd_nq_i;
                q_cnt_o       <= '0;
                err_timeout_o <= 1'b0;
                err_ovf_o     <= 1'b0;
                err_short_o   <= 1'b0;
            end else begin
                q_cnt_o <= q_nx;
                if (drop) err_ovf_o <= 1'b1;
                if ((state == S_WAIT_BUSY) && win_hit) err_timeout_o <= 1'b1;
                if (run && sw_busy_i && to_hit) err_timeout_o <= 1'b1;
                // A result arriving on the busy-fall cycle counts toward the query total.
                if (run && ~sw_busy_i && (nq != '0) && (q_nx != nq)) err_short_o <= 1'b1;
            end
            win_cnt <= (state == S_WAIT_BUSY) ? win_cnt + 1'b1 : '0;
            wd_cnt  <= (run && ~sw_valid_i) ? wd_cnt + 1'b1 : '0;
            if (push_req && !drop) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_req && !drop) mem[wr_ptr[AW-1:0]] <= {q_cnt_o, sw_match_idx_i, sw_max_result_i};
    end
endmodule

// File: tb/tb_sw_job_ctrl.sv
// tb/tb_sw_job_ctrl.sv - directed bench with a queue-based job model for sw_job_ctrl
module tb_sw_job_ctrl;
    localparam int CW = 16, TW = 10, MW = 8, QW = 8, FD = 4, TO = 50000, SWIN = 8;
    localparam int EW = QW + TW + CW;

    logic clk = 1'b0, rst_n = 1'b0;
    logic cmd_valid_i = 0, cmd_ready_o;
    logic [QW-1:0] cmd_nq_i = '0;
    logic [MW-1:0] cmd_match_i = '0, cmd_mismatch_i = '0, cmd_alpha_i = '0, cmd_beta_i = '0;
    logic [MW-1:0] sw_match_o, sw_mismatch_o, sw_alpha_o, sw_beta_o;
    logic sw_start_o, sw_busy_i = 0, sw_valid_i = 0, sw_change_q_i = 0;
    logic [TW-1:0] sw_match_idx_i = '0;
    logic [CW-1:0] sw_max_result_i = '0;
    logic res_valid_o, res_ready_i = 0;
    logic [QW-1:0] res_q_idx_o, q_cnt_o;
    logic [TW-1:0] res_t_idx_o;
    logic [CW-1:0] res_score_o;
    logic done_o, err_timeout_o, err_ovf_o, err_short_o;

    sw_job_ctrl #(.CALC_W(CW), .TIDX_W(TW), .MATCH_W(MW), .QIDX_W(QW),
                  .FIFO_DEPTH(FD), .TIMEOUT(TO), .START_WIN(SWIN)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_nq_i(cmd_nq_i), .cmd_match_i(cmd_match_i), .cmd_mismatch_i(cmd_mismatch_i),
        .cmd_alpha_i(cmd_alpha_i), .cmd_beta_i(cmd_beta_i), .sw_match_o(sw_match_o),
        .sw_mismatch_o(sw_mismatch_o), .sw_alpha_o(sw_alpha_o), .sw_beta_o(sw_beta_o),
        .sw_start_o(sw_start_o), .sw_busy_i(sw_busy_i), .sw_valid_i(sw_valid_i),
        .sw_change_q_i(sw_change_q_i), .sw_match_idx_i(sw_match_idx_i),
        .sw_max_result_i(sw_max_result_i), .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
        .res_q_idx_o(res_q_idx_o), .res_t_idx_o(res_t_idx_o), .res_score_o(res_score_o),
        .done_o(done_o), .q_cnt_o(q_cnt_o), .err_timeout_o(err_timeout_o),
        .err_ovf_o(err_ovf_o), .err_short_o(err_short_o));

    always #5 clk = ~clk;

    int n_vec = 0, n_miss = 0;
    bit chk_on = 0;

    // Job model: phase name, counters of silent cycles, and the result queue.
    string m_ph = "IDLE";
    int m_silent = 0, m_idle = 0;
    logic [QW-1:0] m_q = '0, m_nq = '0;
    logic [MW-1:0] m_cfg [4] = '{default: '0};
    bit m_to = 0, m_ovf = 0, m_short = 0;
    logic [EW-1:0] m_fifo [$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ph = "IDLE"; m_silent = 0; m_idle = 0; m_q = '0; m_nq = '0;
        m_cfg = '{default: '0}; m_to = 0; m_ovf = 0; m_short = 0;
        m_fifo.delete();
    endtask

    task automatic model_step();
        if (m_fifo.size() != 0 && res_ready_i) void'(m_fifo.pop_front());
        if (m_ph == "IDLE" || m_ph == "DONE") begin
            if (cmd_valid_i) begin
                m_cfg = '{cmd_match_i, cmd_mismatch_i, cmd_alpha_i, cmd_beta_i};
                m_nq = cmd_nq_i; m_q = '0; m_to = 0; m_ovf = 0; m_short = 0;
                m_ph = "LAUNCH";
            end
        end else if (m_ph == "LAUNCH") begin
            m_ph = "WAIT"; m_silent = 0;
        end else if (m_ph == "WAIT") begin
            if (sw_busy_i) begin
                m_ph = "RUN"; m_idle = 0;
            end else begin
                m_silent++;
                if (m_silent == SWIN) begin m_ph = "DONE"; m_to = 1; end
            end
        end else if (m_ph == "RUN") begin
            if (sw_valid_i && sw_change_q_i) begin
                if (m_fifo.size() < FD) m_fifo.push_back({m_q, sw_match_idx_i, sw_max_result_i});
                else m_ovf = 1;
                m_q = m_q + 1'b1;
            end
            if (sw_valid_i) m_idle = 0; else m_idle++;
            if (!sw_busy_i) begin
                m_ph = "DONE";
                if (m_nq != 0 && m_q != m_nq) m_short = 1;
            end else if (m_idle == TO) begin
                m_ph = "DONE"; m_to = 1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step(); else model_reset();
        @(negedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send_cmd(input logic [QW-1:0] nq, input logic [MW-1:0] base);
        cmd_valid_i = 1; cmd_nq_i = nq;
        cmd_match_i = base; cmd_mismatch_i = base + 1; cmd_alpha_i = base + 2; cmd_beta_i = base + 3;
        tick();
        cmd_valid_i = 0;
    endtask

    task automatic query(input logic [TW-1:0] idx, input logic [CW-1:0] sc);
        sw_valid_i = 1; sw_change_q_i = 1; sw_match_idx_i = idx; sw_max_result_i = sc;
        tick();
        sw_valid_i = 0; sw_change_q_i = 0;
    endtask

    task automatic head_is(input string nm, input int q, input int t, input int s);
        chk({nm, "_valid"}, res_valid_o, 1);
        chk({nm, "_q"}, res_q_idx_o, q);
        chk({nm, "_t"}, res_t_idx_o, t);
        chk({nm, "_score"}, res_score_o, s);
    endtask

    initial forever begin
        @(negedge clk);
        if (chk_on && rst_n) begin
            chk("cmd_ready", cmd_ready_o, (m_ph == "IDLE" || m_ph == "DONE"));
            chk("sw_start", sw_start_o, m_ph == "LAUNCH");
            chk("done", done_o, m_ph == "DONE");
            chk("q_cnt", q_cnt_o, m_q);
            chk("err_timeout", err_timeout_o, m_to);
            chk("err_ovf", err_ovf_o, m_ovf);
            chk("err_short", err_short_o, m_short);
            chk("cfg", {sw_match_o, sw_mismatch_o, sw_alpha_o, sw_beta_o},
                {m_cfg[0], m_cfg[1], m_cfg[2], m_cfg[3]});
            chk("res_valid", res_valid_o, m_fifo.size() != 0);
            chk("res_head", {res_q_idx_o, res_t_idx_o, res_score_o},
                m_fifo.size() != 0 ? m_fifo[0] : '0);
        end
    end

    initial begin
        #3;
        chk("rst_ready", cmd_ready_o, 0);
        chk("rst_start", sw_start_o, 0);
        chk("rst_res_valid", res_valid_o, 0);
        tick(); tick();
        rst_n = 1; chk_on = 1;
        tick();
        chk("idle_ready", cmd_ready_o, 1);

        // Basic job: busy three cycles after start, two best-match updates.
        send_cmd(8'd2, 8'd2);
        chk("t1_start", sw_start_o, 1);
        tick();
        chk("t1_start_once", sw_start_o, 0);
        tick();
        sw_busy_i = 1; tick();
        tick();
        query(10'd1, 16'd18);
        tick();
        query(10'd0, 16'd30);
        sw_busy_i = 0; tick();
        chk("t1_done", done_o, 1);
        chk("t1_errs", {err_timeout_o, err_ovf_o, err_short_o}, 0);
        head_is("t1_e0", 0, 1, 18);
        res_ready_i = 1; tick();
        head_is("t1_e1", 1, 0, 30);
        tick(); res_ready_i = 0;
        chk("t1_empty", res_valid_o, 0);

        // Core never raises busy: start window expires after eight cycles.
        send_cmd(8'd0, 8'd9);
        ticks(SWIN);
        chk("t2_not_yet", done_o, 0);
        tick();
        chk("t2_done", done_o, 1);
        chk("t2_timeout", err_timeout_o, 1);

        // Watchdog in RUN with no core valid.
        sw_busy_i = 1;
        send_cmd(8'd0, 8'd4);
        ticks(2);
        ticks(TO - 1);
        chk("t3_not_yet", done_o, 0);
        tick();
        chk("t3_done", done_o, 1);
        chk("t3_timeout", err_timeout_o, 1);

        // Overflow: five results with the host not draining.
        send_cmd(8'd0, 8'd6);
        chk("t4_timeout_clr", err_timeout_o, 0);
        ticks(2);
        for (int i = 0; i < 5; i++) begin
            query(10'(i), 16'(10 + i));
            tick();
        end
        sw_busy_i = 0; tick();
        chk("t4_q_cnt", q_cnt_o, 5);
        chk("t4_ovf", err_ovf_o, 1);
        head_is("t4_head", 0, 0, 10);

        // Short job; also push and pop on the same cycle while full.
        sw_busy_i = 1;
        send_cmd(8'd3, 8'd1);
        ticks(2);
        res_ready_i = 1;
        query(10'd7, 16'd40);
        chk("t5_no_ovf", err_ovf_o, 0);
        ticks(3);
        res_ready_i = 0;
        query(10'd2, 16'd44);
        sw_busy_i = 0; tick();
        chk("t5_done", done_o, 1);
        chk("t5_short", err_short_o, 1);
        chk("t5_ovf", err_ovf_o, 0);
        head_is("t5_head", 0, 7, 40);

        // Asynchronous reset in the middle of a run.
        res_ready_i = 1; ticks(2); res_ready_i = 0;
        sw_busy_i = 1;
        send_cmd(8'd0, 8'd5);
        ticks(2);
        query(10'd3, 16'd3);
        tick();
        rst_n = 0;
        #1;
        chk("t6_q_cnt", q_cnt_o, 0);
        chk("t6_cfg", {sw_match_o, sw_mismatch_o, sw_alpha_o, sw_beta_o}, 0);
        chk("t6_res_valid", res_valid_o, 0);
        chk("t6_ready", cmd_ready_o, 0);
        chk("t6_done", done_o, 0);
        chk("t6_errs", {err_timeout_o, err_ovf_o, err_short_o, sw_start_o}, 0);
        sw_busy_i = 0;
        tick();
        rst_n = 1;
        tick();
        chk("t6_idle_ready", cmd_ready_o, 1);
        chk("t6_idle_empty", res_valid_o, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
